data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 29 ++
 rtl/data_mem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: two ports (0 = CPU,
// 1 = loader/DMA) packed per port, plus the shared response channel.
interface data_mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [1:0]                    req;
    logic [1:0]                    lock;
    logic [1:0]                    we;
    logic [1:0]                    byte_op;
    logic [1:0][ADDRESS_WIDTH-1:0] addr;
    logic [1:0][DATA_WIDTH-1:0]    wdata;
    logic [1:0]                    gnt;
    logic [1:0]                    rvalid;
    logic [1:0]                    err;
    logic [DATA_WIDTH-1:0]         rdata;

    // requesters drive commands and observe grant/response
    modport master (
        output req, lock, we, byte_op, addr, wdata,
        input  gnt, rvalid, err, rdata
    );

    // the arbiter consumes commands and produces grant/response
    modport slave (
        input  req, lock, we, byte_op, addr, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter with burst lock and burst-length limit.
// Pipeline: grant (N, combinational) -> command register drives memory (N+1)
// -> response register returns rvalid/rdata/err (N+2).
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking;
// otherwise port 0 wins every tie. Lock/burst behaviour is the same in both.
module data_mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_MAX     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    data_mem_arbiter_if.slave        bus,
    output logic                     mem_we,
    output logic                     mem_byte_op,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    localparam int CW = (BURST_MAX < 4) ? 2 : $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t    state, state_nxt;
    logic          owner, owner_nxt;     // port holding the lock
    logic [CW-1:0] burst_cnt, cnt_nxt;   // consecutive locked grants
    logic [1:0]    req_q;
    logic [1:0]    gnt_c;
    logic          take;
    logic          gport;
    logic          open_arb;
    logic          tie_winner;

    // pipeline valid bits: [0] command stage (memory cycle), [1] response stage
    logic [1:0]               vld_pipe;
    logic                     cmd_port, cmd_we, cmd_byte, cmd_mis;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;
    logic                     rsp_port, rsp_err;
    logic [DATA_WIDTH-1:0]    rsp_rdata;

    // requests are masked during reset so no grant can be issued
    assign req_q = bus.req & {2{rst_n}};

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr, ptr_nxt;               // port that wins the next tie

    // round-robin pointer: the port just granted loses the next tie
    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr <= 1'b0;
        else        rr_ptr <= ptr_nxt;
    end

    assign ptr_nxt    = take ? ~gport : rr_ptr;
    assign tie_winner = rr_ptr;
`else
    assign tie_winner = 1'b0;
`endif

    // arbitration state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_OPEN;
            owner     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // grant selection, lock tracking and burst-limit yield
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = burst_cnt;
        gnt_c     = 2'b00;
        take      = 1'b0;
        gport     = 1'b0;
        open_arb  = 1'b1;

        if (state == ARB_LOCKED && req_q[owner] && bus.lock[owner]) begin
            // lock still held: owner keeps priority except for one yield slot
            open_arb = 1'b0;
            take     = 1'b1;
            if (burst_cnt >= BURST_LIM) begin
                if (req_q[~owner]) begin
                    gport   = ~owner;
                    cnt_nxt = '0;
                end else begin
                    // nobody to yield to: this grant starts a fresh count
                    gport   = owner;
                    cnt_nxt = CW'(1);
                end
            end else begin
                gport   = owner;
                cnt_nxt = burst_cnt + CW'(1);
            end
        end

        if (open_arb) begin
            // no live lock: plain arbitration, burst over
            state_nxt = ARB_OPEN;
            cnt_nxt   = '0;
            if (req_q != 2'b00) begin
                take  = 1'b1;
                gport = (req_q == 2'b11) ? tie_winner : req_q[1];
                if (bus.lock[gport]) begin
                    state_nxt = ARB_LOCKED;
                    owner_nxt = gport;
                    cnt_nxt   = CW'(1);
                end
            end
        end

        if (take) gnt_c[gport] = 1'b1;
    end

    assign bus.gnt = gnt_c;

    // command register: captures the granted request, holds it while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[0] <= 1'b0;
            cmd_port    <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_byte    <= 1'b0;
            cmd_mis     <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
        end else begin
            vld_pipe[0] <= take;
            if (take) begin
                cmd_port  <= gport;
                cmd_we    <= bus.we[gport];
                cmd_byte  <= bus.byte_op[gport];
                cmd_mis   <= ~bus.byte_op[gport] & (bus.addr[gport][1:0] != 2'b00);
                cmd_addr  <= bus.addr[gport];
                cmd_wdata <= bus.wdata[gport];
            end
        end
    end

    // misaligned words never write; reset suppresses an in-flight write
    assign mem_we      = rst_n & vld_pipe[0] & cmd_we & ~cmd_mis;
    assign mem_byte_op = cmd_byte;
    assign mem_addr    = cmd_addr;
    assign mem_wdata   = cmd_wdata;

    // response register: samples memory read data, zero for writes/errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            rsp_port    <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            rsp_port    <= cmd_port;
            rsp_err     <= vld_pipe[0] & cmd_mis;
            if (vld_pipe[0] && !cmd_we && !cmd_mis) rsp_rdata <= mem_rdata;
            else                                    rsp_rdata <= '0;
        end
    end

    assign bus.rvalid = {2{vld_pipe[1]}} & {rsp_port, ~rsp_port};
    assign bus.err    = {2{vld_pipe[1] & rsp_err}} & {rsp_port, ~rsp_port};
    assign bus.rdata  = rsp_rdata;

endmodule
